// File: rtl/branch_predictor_if.sv
// Lookup/update bus between the fetch/execute pipeline and the branch predictor.
//   master : pipeline side   (drives IF PC, EX resolution, FENCE.I clear)
//   slave  : predictor side  (returns prediction, mispredict flag, perf counters)
interface branch_predictor_if #(
    parameter int unsigned IDX_W = 4
);
    logic [31:0]      i_if_pc;
    logic             o_pred_hit;
    logic             o_pred_taken;
    logic [31:0]      o_pred_target;
    logic [IDX_W-1:0] o_pred_ghr;
    logic             i_upd_vld;
    logic [31:0]      i_upd_pc;
    logic [IDX_W-1:0] i_upd_ghr;
    logic             i_upd_is_br;
    logic             i_upd_is_jmp;
    logic             i_upd_taken;
    logic [31:0]      i_upd_target;
    logic             i_upd_pred_taken;
    logic [31:0]      i_upd_pred_target;
    logic             i_clr;
    logic             o_mispred;
    logic [31:0]      o_br_cnt;
    logic [31:0]      o_mispred_cnt;

    modport master (
        output i_if_pc, i_upd_vld, i_upd_pc, i_upd_ghr, i_upd_is_br, i_upd_is_jmp,
               i_upd_taken, i_upd_target, i_upd_pred_taken, i_upd_pred_target, i_clr,
        input  o_pred_hit, o_pred_taken, o_pred_target, o_pred_ghr,
               o_mispred, o_br_cnt, o_mispred_cnt
    );

    modport slave (
        input  i_if_pc, i_upd_vld, i_upd_pc, i_upd_ghr, i_upd_is_br, i_upd_is_jmp,
               i_upd_taken, i_upd_target, i_upd_pred_taken, i_upd_pred_target, i_clr,
        output o_pred_hit, o_pred_taken, o_pred_target, o_pred_ghr,
               o_mispred, o_br_cnt, o_mispred_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with saturating counters,
// optional gshare indexing, mispredict detection and performance counters.
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   bp (slave)     : IF lookup (combinational), EX update (one per cycle),
//                    i_clr invalidate-all, o_mispred, o_br_cnt, o_mispred_cnt
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned GSHARE  = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    branch_predictor_if.slave bp
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] jmp_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q [ENTRIES];
    logic [IDX_W-1:0]   ghr_q;
    logic [31:0]        br_cnt_q;
    logic [31:0]        mis_cnt_q;

    logic [IDX_W-1:0]   lu_idx;
    logic [IDX_W-1:0]   up_idx;
    logic               lu_hit;
    logic               up_hit;
    logic               upd_qual;
    logic               mispred_c;
    logic [CTR_W-1:0]   up_ctr_nxt;
    logic               unused_pc_lsbs;

    // Index hashing; the GHR contribution is compiled out for plain PC indexing
    assign lu_idx = bp.i_if_pc[IDX_W+1:2]  ^ ((GSHARE != 0) ? ghr_q        : '0);
    assign up_idx = bp.i_upd_pc[IDX_W+1:2] ^ ((GSHARE != 0) ? bp.i_upd_ghr : '0);

    assign lu_hit = valid_q[lu_idx] && (tag_q[lu_idx] == bp.i_if_pc[31:IDX_W+2]);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == bp.i_upd_pc[31:IDX_W+2]);

    assign bp.o_pred_hit    = lu_hit;
    assign bp.o_pred_taken  = lu_hit & (jmp_q[lu_idx] | ctr_q[lu_idx][CTR_W-1]);
    assign bp.o_pred_target = lu_hit ? tgt_q[lu_idx] : 32'd0;
    assign bp.o_pred_ghr    = ghr_q;

    assign upd_qual  = bp.i_upd_vld & (bp.i_upd_is_br | bp.i_upd_is_jmp);
    assign mispred_c = upd_qual & ((bp.i_upd_taken != bp.i_upd_pred_taken) |
                       (bp.i_upd_taken & (bp.i_upd_target != bp.i_upd_pred_target)));
    assign bp.o_mispred     = mispred_c;
    assign bp.o_br_cnt      = br_cnt_q;
    assign bp.o_mispred_cnt = mis_cnt_q;

    // Word-aligned PCs: the two LSBs carry no information
    assign unused_pc_lsbs = ^{bp.i_if_pc[1:0], bp.i_upd_pc[1:0]};

    // Saturating counter step for the entry being updated
    always_comb begin
        up_ctr_nxt = ctr_q[up_idx];
        if (bp.i_upd_taken) begin
            if (up_ctr_nxt != CTR_MAX) up_ctr_nxt = up_ctr_nxt + CTR_W'(1);
        end else begin
            if (up_ctr_nxt != '0) up_ctr_nxt = up_ctr_nxt - CTR_W'(1);
        end
    end

    // BTB storage; a clear takes precedence over a same-cycle write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            jmp_q   <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= CTR_WNT;
            end
        end else if (bp.i_clr) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (upd_qual) begin
            if (up_hit) begin
                if (bp.i_upd_is_jmp) begin
                    tgt_q[up_idx] <= bp.i_upd_target;
                    jmp_q[up_idx] <= 1'b1;
                end else begin
                    ctr_q[up_idx] <= up_ctr_nxt;
                    if (bp.i_upd_taken) tgt_q[up_idx] <= bp.i_upd_target;
                end
            end else if (bp.i_upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= bp.i_upd_pc[31:IDX_W+2];
                tgt_q[up_idx]   <= bp.i_upd_target;
                jmp_q[up_idx]   <= bp.i_upd_is_jmp;
                ctr_q[up_idx]   <= CTR_WT;
            end
        end
    end

    // Non-speculative global history and saturating performance counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ghr_q     <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if ((GSHARE != 0) && upd_qual && bp.i_upd_is_br)
                ghr_q <= {ghr_q[IDX_W-2:0], bp.i_upd_taken};
            if (upd_qual && (br_cnt_q != 32'hFFFF_FFFF))
                br_cnt_q <= br_cnt_q + 32'd1;
            if (mispred_c && (mis_cnt_q != 32'hFFFF_FFFF))
                mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: one PC-indexed and one gshare instance.
module tb_branch_predictor;
    localparam int unsigned IDX_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if #(.IDX_W(IDX_W)) bp0 ();
    branch_predictor_if #(.IDX_W(IDX_W)) bp1 ();

    branch_predictor #(.ENTRIES(16), .CTR_W(2), .GSHARE(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bp(bp0));
    branch_predictor #(.ENTRIES(16), .CTR_W(2), .GSHARE(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bp(bp1));

    typedef enum int {
        S_HIT0, S_TAKEN0, S_TGT0, S_GHR0, S_MIS0, S_BR0, S_MC0,
        S_HIT1, S_TAKEN1, S_TGT1, S_GHR1, S_MIS1
    } sig_e;
    typedef struct {
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_br0 = 0, m_mc0 = 0;
    logic [IDX_W-1:0] m_ghr1 = '0;

    function automatic logic [31:0] obs(sig_e s);
        case (s)
            S_HIT0:   return 32'(bp0.o_pred_hit);
            S_TAKEN0: return 32'(bp0.o_pred_taken);
            S_TGT0:   return bp0.o_pred_target;
            S_GHR0:   return 32'(bp0.o_pred_ghr);
            S_MIS0:   return 32'(bp0.o_mispred);
            S_BR0:    return bp0.o_br_cnt;
            S_MC0:    return bp0.o_mispred_cnt;
            S_HIT1:   return 32'(bp1.o_pred_hit);
            S_TAKEN1: return 32'(bp1.o_pred_taken);
            S_TGT1:   return bp1.o_pred_target;
            S_GHR1:   return 32'(bp1.o_pred_ghr);
            S_MIS1:   return 32'(bp1.o_mispred);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, want, $time);
        end
    endtask

    task automatic push(input sig_e s, input logic [31:0] v);
        exp_t e;
        e.sig = s;
        e.exp = v;
        exp_q.push_back(e);
    endtask

    // Sample 1 time unit after the drive point and retire every pending expectation
    task automatic drain();
        exp_t e;
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq(e.sig.name(), obs(e.sig), e.exp);
        end
    endtask

    task automatic look0(input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] tgt);
        bp0.i_if_pc = pc;
        push(S_HIT0, 32'(hit)); push(S_TAKEN0, 32'(tk)); push(S_TGT0, tgt);
        push(S_GHR0, 32'd0); push(S_BR0, m_br0); push(S_MC0, m_mc0);
        drain();
    endtask

    task automatic look1(input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] tgt);
        bp1.i_if_pc = pc;
        push(S_HIT1, 32'(hit)); push(S_TAKEN1, 32'(tk)); push(S_TGT1, tgt);
        push(S_GHR1, 32'(m_ghr1));
        drain();
    endtask

    function automatic logic exp_mis(input logic qual, input logic taken, input logic [31:0] tgt,
                                     input logic ptk, input logic [31:0] ptgt);
        return qual & ((taken != ptk) | (taken & (tgt != ptgt)));
    endfunction

    // Drive one update cycle on the PC-indexed instance; model counters after the edge
    task automatic upd0(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                        input logic is_br, input logic is_jmp, input logic ptk,
                        input logic [31:0] ptgt, input logic clr);
        logic qual, mis;
        qual = is_br | is_jmp;
        mis  = exp_mis(qual, taken, tgt, ptk, ptgt);
        bp0.i_upd_vld = 1'b1; bp0.i_upd_pc = pc; bp0.i_upd_target = tgt;
        bp0.i_upd_taken = taken; bp0.i_upd_is_br = is_br; bp0.i_upd_is_jmp = is_jmp;
        bp0.i_upd_pred_taken = ptk; bp0.i_upd_pred_target = ptgt; bp0.i_clr = clr;
        push(S_MIS0, 32'(mis));
        drain();
        @(negedge clk);
        if (qual) m_br0++;
        if (mis)  m_mc0++;
        bp0.i_upd_vld = 1'b0; bp0.i_clr = 1'b0;
    endtask

    task automatic upd1(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                        input logic is_br, input logic is_jmp, input logic [IDX_W-1:0] ghr);
        bp1.i_upd_vld = 1'b1; bp1.i_upd_pc = pc; bp1.i_upd_target = tgt;
        bp1.i_upd_taken = taken; bp1.i_upd_is_br = is_br; bp1.i_upd_is_jmp = is_jmp;
        bp1.i_upd_pred_taken = 1'b0; bp1.i_upd_pred_target = 32'd0; bp1.i_upd_ghr = ghr;
        push(S_MIS1, 32'(exp_mis(is_br | is_jmp, taken, tgt, 1'b0, 32'd0)));
        drain();
        @(negedge clk);
        if (is_br) m_ghr1 = {m_ghr1[IDX_W-2:0], taken};
        bp1.i_upd_vld = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bp0.i_if_pc = 32'h40; bp0.i_upd_vld = 0; bp0.i_upd_pc = 0; bp0.i_upd_ghr = '0;
        bp0.i_upd_is_br = 0; bp0.i_upd_is_jmp = 0; bp0.i_upd_taken = 0; bp0.i_upd_target = 0;
        bp0.i_upd_pred_taken = 0; bp0.i_upd_pred_target = 0; bp0.i_clr = 0;
        bp1.i_if_pc = 32'h0; bp1.i_upd_vld = 0; bp1.i_upd_pc = 0; bp1.i_upd_ghr = '0;
        bp1.i_upd_is_br = 0; bp1.i_upd_is_jmp = 0; bp1.i_upd_taken = 0; bp1.i_upd_target = 0;
        bp1.i_upd_pred_taken = 0; bp1.i_upd_pred_target = 0; bp1.i_clr = 0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        look0(32'h40, 0, 0, 32'h0);

        // Allocate on a taken branch; same-cycle lookup still sees the old entry
        bp0.i_if_pc = 32'h40;
        push(S_HIT0, 32'd0);
        upd0(32'h40, 32'h100, 1, 1, 0, 0, 32'h0, 0);
        look0(32'h40, 1, 1, 32'h100);

        // Counter hysteresis 2->1->0->1->2->3->2
        upd0(32'h40, 32'h44,  0, 1, 0, 1, 32'h100, 0);  look0(32'h40, 1, 0, 32'h100);
        upd0(32'h40, 32'h44,  0, 1, 0, 0, 32'h100, 0);  look0(32'h40, 1, 0, 32'h100);
        upd0(32'h40, 32'h100, 1, 1, 0, 0, 32'h100, 0);  look0(32'h40, 1, 0, 32'h100);
        upd0(32'h40, 32'h100, 1, 1, 0, 0, 32'h100, 0);  look0(32'h40, 1, 1, 32'h100);
        upd0(32'h40, 32'h100, 1, 1, 0, 1, 32'h100, 0);  look0(32'h40, 1, 1, 32'h100);
        upd0(32'h40, 32'h44,  0, 1, 0, 1, 32'h100, 0);  look0(32'h40, 1, 1, 32'h100);

        // Target mismatch counts as a mispredict and rewrites the target
        upd0(32'h40, 32'h180, 1, 1, 0, 1, 32'h100, 0);  look0(32'h40, 1, 1, 32'h180);

        // Non-control-flow update is ignored and not counted
        upd0(32'h40, 32'h999, 1, 0, 0, 0, 32'h0, 0);    look0(32'h40, 1, 1, 32'h180);

        // Aliasing: 0x440 shares index 0 and evicts 0x40
        upd0(32'h440, 32'h200, 1, 1, 0, 0, 32'h0, 0);
        look0(32'h40, 0, 0, 32'h0);
        look0(32'h440, 1, 1, 32'h200);

        // Jump allocation, then jump hit with a new target
        upd0(32'h84, 32'h300, 1, 0, 1, 0, 32'h0, 0);    look0(32'h84, 1, 1, 32'h300);
        upd0(32'h84, 32'h340, 1, 0, 1, 1, 32'h300, 0);  look0(32'h84, 1, 1, 32'h340);

        // Miss and not taken: no allocation
        upd0(32'h48, 32'h4C, 0, 1, 0, 0, 32'h0, 0);     look0(32'h48, 0, 0, 32'h0);

        // Clear with a same-cycle allocating update: write dropped, counted anyway
        upd0(32'h4C, 32'h600, 1, 1, 0, 0, 32'h0, 1);
        look0(32'h4C, 0, 0, 32'h0);
        look0(32'h84, 0, 0, 32'h0);
        look0(32'h440, 0, 0, 32'h0);

        // Allocation after clear starts weakly taken
        upd0(32'h40, 32'h100, 1, 1, 0, 0, 32'h0, 0);    look0(32'h40, 1, 1, 32'h100);

        // Async reset mid-update: state clears before the next edge, update lost
        bp0.i_upd_vld = 1'b1; bp0.i_upd_pc = 32'h240; bp0.i_upd_target = 32'h700;
        bp0.i_upd_taken = 1'b1; bp0.i_upd_is_br = 1'b1; bp0.i_upd_is_jmp = 1'b0;
        bp0.i_upd_pred_taken = 1'b0; bp0.i_upd_pred_target = 32'h0;
        bp0.i_if_pc = 32'h40;
        #2;
        rst_n = 1'b0;
        m_br0 = 0; m_mc0 = 0; m_ghr1 = '0;
        push(S_HIT0, 32'd0); push(S_TAKEN0, 32'd0); push(S_TGT0, 32'd0);
        push(S_BR0, 32'd0); push(S_MC0, 32'd0); push(S_MIS0, 32'd1);
        drain();
        @(negedge clk);
        bp0.i_upd_vld = 1'b0;
        rst_n = 1'b1;
        look0(32'h240, 0, 0, 32'h0);
        look0(32'h40, 0, 0, 32'h0);

        // Gshare: history T,T,N -> 0b0110
        upd1(32'h1000, 32'h2000, 1, 1, 0, 4'd0);
        upd1(32'h1000, 32'h2000, 1, 1, 0, 4'd1);
        upd1(32'h1000, 32'h2000, 0, 1, 0, 4'd3);
        look1(32'h0, 0, 0, 32'h0);
        // Jump written at index 6 (pc 0 ^ ghr 6); jumps leave the GHR alone
        upd1(32'h0, 32'h500, 1, 0, 1, 4'd6);
        look1(32'h0, 1, 1, 32'h500);
        // pc 0x1018 hashes to index 0, where the first branch was allocated
        look1(32'h1018, 1, 1, 32'h2000);
        // pc 0x1000 hashes to index 6 but its tag differs
        look1(32'h1000, 0, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the RV32I 5-stage pipeline, replacing the fixed predict-not-taken fetch path in which the mispredict flag is constant 0. Lookup is combinational on the IF-stage PC. Resolution comes from the EX stage one update per cycle. The block holds a direct-mapped branch target buffer (BTB) with saturating counters, an optional gshare global history register, mispredict detection and performance counters.

## Interface
Parameters:
- ENTRIES, 16, BTB entries; power of two, 4..256; IDX_W = log2(ENTRIES)
- CTR_W, 2, saturating counter width, 1..4
- GSHARE, 0, 0 = index by PC; 1 = index by PC XOR global history

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_if_pc  in  32  IF-stage fetch PC
- o_pred_hit  out  1  BTB tag hit for i_if_pc
- o_pred_taken  out  1  predicted taken
- o_pred_target  out  32  predicted target; valid when o_pred_taken
- o_pred_ghr  out  IDX_W  GHR snapshot; the pipeline carries it to EX
- i_upd_vld  in  1  EX has a resolved control-flow instruction
- i_upd_pc  in  32  PC of the resolved instruction
- i_upd_ghr  in  IDX_W  GHR snapshot carried from its fetch
- i_upd_is_br  in  1  conditional branch
- i_upd_is_jmp  in  1  JAL/JALR
- i_upd_taken  in  1  actual outcome
- i_upd_target  in  32  actual target (ALU result)
- i_upd_pred_taken  in  1  prediction made at fetch
- i_upd_pred_target  in  32  target predicted at fetch
- i_clr  in  1  synchronous invalidate-all (FENCE.I)
- o_mispred  out  1  resolved instruction was mispredicted
- o_br_cnt  out  32  resolved control-flow count
- o_mispred_cnt  out  32  mispredict count

## Operation
- Entry contents: valid, tag = pc[31:IDX_W+2], target[31:0], is_jmp, ctr[CTR_W-1:0].
- Lookup index:
  - GSHARE=0: i_if_pc[IDX_W+1:2].
  - GSHARE=1: i_if_pc[IDX_W+1:2] ^ ghr.
  - Update index uses i_upd_pc with i_upd_ghr in the same way.
- Hit: valid and tag match. o_pred_taken = hit & (is_jmp | ctr[CTR_W-1]). o_pred_target = entry target, or 0 when no hit.
- Update applies when i_upd_vld & (i_upd_is_br | i_upd_is_jmp). The other i_upd_vld cycles are ignored and not counted.
  - Tag hit, branch: ctr increments if taken, decrements if not taken, saturating at 0 and 2^CTR_W-1. Target is rewritten when taken.
  - Tag hit, jump: target rewritten, is_jmp set.
  - Miss and taken: allocate and overwrite whatever entry is there. Valid=1, tag and target written, is_jmp = i_upd_is_jmp, ctr = 2^(CTR_W-1) (weakly taken).
  - Miss and not taken: no allocation.
- GHR (GSHARE=1 only): on a branch update, ghr <= {ghr[IDX_W-2:0], i_upd_taken}. This is non-speculative. Jumps do not shift the GHR. With GSHARE=0 the GHR is held at 0.
- o_mispred (combinational) = qualified update & ((i_upd_taken != i_upd_pred_taken) | (i_upd_taken & i_upd_target != i_upd_pred_target)).
- Counters: o_br_cnt increments on each qualified update. o_mispred_cnt increments when o_mispred is high. Both saturate at 0xFFFF_FFFF.
- i_clr: all valid bits cleared and all ctr set to 2^(CTR_W-1)-1. GHR and performance counters are unaffected.
  - i_clr together with an update: i_clr wins and the update's BTB write is dropped.
  - The GHR shift and counter increments from that update still occur.

## Timing
- Lookup outputs are combinational from i_if_pc and state, with zero latency.
- o_mispred is combinational from the update inputs.
- BTB, GHR and counter writes take effect on the next rising edge.
- No write-to-read bypass: a lookup in the same cycle as an update to the same index sees the old contents.
- Reset (async assert, sync to edge on deassert):
  - every valid = 0, every ctr = 2^(CTR_W-1)-1, ghr = 0, o_br_cnt = o_mispred_cnt = 0.
  - Hence o_pred_hit = o_pred_taken = 0 and o_pred_target = 0. o_mispred follows its inputs.
- Reset asserted mid-update: the update is lost and reset state applies immediately.

## Test plan
- Reset, then lookup 0x0000_0040 -> hit=0, taken=0, target=0, both counters 0.
- Taken branch update pc=0x40, target=0x100, pred_taken=0 -> o_mispred=1 that cycle. Next cycle lookup 0x40 gives hit=1, taken=1, target=0x100. br_cnt=1, mispred_cnt=1.
- Counter hysteresis, CTR_W=2 on the entry above: two not-taken updates -> ctr 2->1->0, pred_taken=0. Three taken updates -> ctr saturates at 3. One not-taken -> still predicts taken.
- Aliasing, ENTRIES=16: allocate pc=0x40, then taken update at pc=0x440 (same index) -> entry replaced. Lookup 0x40 -> hit=0; lookup 0x440 -> hit=1.
- GSHARE=1: history of taken,taken,not-taken gives ghr=0b0110. Lookup at pc 0x0 uses index 6; update with i_upd_ghr=6 writes index 6.
- i_clr asserted in the same cycle as an allocating update -> all hit=0 next cycle. br_cnt still increments. Separately, asynchronous reset pulsed mid-stream -> all outputs return to reset values before the next edge.
